register_pc_unit: RTL and testbench

- Architectural state block for the maxicore32 CPU.
- Contains two submodules:
  - register_file: 16 x 32-bit general registers, three asynchronous read ports, one write port with full-word and 16-bit immediate write modes.
  - program_counter: 32-bit PC supporting increment-by-4 and absolute jump.
- Sits between the instruction decoder/ALU and the memory fetch path. Submodules keep the names register_file and program_counter.
- Immediate-type encodings are shared via the registers header.

---
 rtl/register_pc_unit.sv | 215 +++++++++++++++++++++
 tb/tb_register_pc_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/register_pc_unit.sv
// register_pc_unit: architectural state block for the maxicore32 CPU.
//
// Holds the general register file and the program counter.
//
// Ports (all state updates happen on the rising edge of clock):
//   clock, reset               - single clock; reset is synchronous and active-high.
//   write_index                - destination register for both write modes.
//   write, write_data          - full-word write.
//   write_immediate,           - 16-bit immediate write.
//   write_immediate_data,
//   write_immediate_type       - IT_BOTTOM / IT_TOP / IT_UNSIGNED / IT_SIGNED.
//   read_regN_index/_data      - three independent combinational read ports.
//   pc_jump, pc_jump_data      - absolute PC load.
//   pc_inc                     - PC advance by 4.
//   pc_read_data               - registered current PC.

// Immediate-type encodings shared with the decoder.
package registers_pkg;
   localparam logic [1:0] IT_BOTTOM   = 2'd0;
   localparam logic [1:0] IT_TOP      = 2'd1;
   localparam logic [1:0] IT_UNSIGNED = 2'd2;
   localparam logic [1:0] IT_SIGNED   = 2'd3;
endpackage

// register_file: NUM_REGS x DATA_WIDTH storage, one write port, three async reads.
// All registers are ordinary storage; there is no hardwired zero register.
// Reads see the array contents directly, so a same-cycle read of the register
// being written still returns the old value.
module register_file
   import registers_pkg::*;
#(
   parameter int NUM_REGS    = 16,
   parameter int DATA_WIDTH  = 32,
   parameter int INDEX_WIDTH = $clog2(NUM_REGS)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [INDEX_WIDTH-1:0] write_index,
   input  logic                   write,
   input  logic [DATA_WIDTH-1:0]  write_data,
   input  logic                   write_immediate,
   input  logic [15:0]            write_immediate_data,
   input  logic [1:0]             write_immediate_type,
   input  logic [INDEX_WIDTH-1:0] read_reg1_index,
   input  logic [INDEX_WIDTH-1:0] read_reg2_index,
   input  logic [INDEX_WIDTH-1:0] read_reg3_index,
   output logic [DATA_WIDTH-1:0]  read_reg1_data,
   output logic [DATA_WIDTH-1:0]  read_reg2_data,
   output logic [DATA_WIDTH-1:0]  read_reg3_data
);

   logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];
   logic [DATA_WIDTH-1:0] current_word_s;
   logic [DATA_WIDTH-1:0] immediate_word_s;
   logic [DATA_WIDTH-1:0] next_word_s;
   logic                  write_en_s;

   assign current_word_s = regs_r[write_index];

   // Merge the 16-bit immediate into the destination word according to its type.
   always_comb begin
      immediate_word_s = current_word_s;
      case (write_immediate_type)
         IT_BOTTOM: begin
            immediate_word_s[15:0] = write_immediate_data;
         end
         IT_TOP: begin
            immediate_word_s[31:16] = write_immediate_data;
         end
         IT_UNSIGNED: begin
            immediate_word_s       = {DATA_WIDTH{1'b0}};
            immediate_word_s[15:0] = write_immediate_data;
         end
         IT_SIGNED: begin
            immediate_word_s       = {DATA_WIDTH{write_immediate_data[15]}};
            immediate_word_s[15:0] = write_immediate_data;
         end
         default: begin
            immediate_word_s = current_word_s;
         end
      endcase
   end

   // Select the value to store; a full write takes precedence over an immediate.
   always_comb begin
      write_en_s  = write | write_immediate;
      next_word_s = current_word_s;
      if (write) begin
         next_word_s = write_data;
      end else if (write_immediate) begin
         next_word_s = immediate_word_s;
      end else begin
         next_word_s = current_word_s;
      end
   end

   // Register array update; reset clears every register and overrides writes.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= {DATA_WIDTH{1'b0}};
         end
      end else if (write_en_s) begin
         regs_r[write_index] <= next_word_s;
      end
   end

   assign read_reg1_data = regs_r[read_reg1_index];
   assign read_reg2_data = regs_r[read_reg2_index];
   assign read_reg3_data = regs_r[read_reg3_index];

endmodule

// program_counter: DATA_WIDTH-bit PC with priority reset > jump > inc > hold.
// Jump targets are taken unmodified; increment wraps modulo 2^DATA_WIDTH.
module program_counter #(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  pc_jump,
   input  logic                  pc_inc,
   input  logic [DATA_WIDTH-1:0] pc_jump_data,
   output logic [DATA_WIDTH-1:0] pc_read_data
);

   logic [DATA_WIDTH-1:0] pc_r;
   logic [DATA_WIDTH-1:0] next_pc_s;

   // Next-PC selection; jump beats increment.
   always_comb begin
      next_pc_s = pc_r;
      if (pc_jump) begin
         next_pc_s = pc_jump_data;
      end else if (pc_inc) begin
         next_pc_s = pc_r + DATA_WIDTH'(32'd4);
      end else begin
         next_pc_s = pc_r;
      end
   end

   // PC register with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         pc_r <= RESET_PC;
      end else begin
         pc_r <= next_pc_s;
      end
   end

   assign pc_read_data = pc_r;

endmodule

// Top level: register file and PC operate independently in the same cycle.
module register_pc_unit #(
   parameter int                    NUM_REGS   = 16,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [3:0]            write_index,
   input  logic                  write,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  write_immediate,
   input  logic [15:0]           write_immediate_data,
   input  logic [1:0]            write_immediate_type,
   input  logic [3:0]            read_reg1_index,
   input  logic [3:0]            read_reg2_index,
   input  logic [3:0]            read_reg3_index,
   output logic [DATA_WIDTH-1:0] read_reg1_data,
   output logic [DATA_WIDTH-1:0] read_reg2_data,
   output logic [DATA_WIDTH-1:0] read_reg3_data,
   input  logic                  pc_jump,
   input  logic                  pc_inc,
   input  logic [DATA_WIDTH-1:0] pc_jump_data,
   output logic [DATA_WIDTH-1:0] pc_read_data
);

   register_file #(
      .NUM_REGS    (NUM_REGS),
      .DATA_WIDTH  (DATA_WIDTH),
      .INDEX_WIDTH (4)
   ) u_register_file (
      .clock                (clock),
      .reset                (reset),
      .write_index          (write_index),
      .write                (write),
      .write_data           (write_data),
      .write_immediate      (write_immediate),
      .write_immediate_data (write_immediate_data),
      .write_immediate_type (write_immediate_type),
      .read_reg1_index      (read_reg1_index),
      .read_reg2_index      (read_reg2_index),
      .read_reg3_index      (read_reg3_index),
      .read_reg1_data       (read_reg1_data),
      .read_reg2_data       (read_reg2_data),
      .read_reg3_data       (read_reg3_data)
   );

   program_counter #(
      .DATA_WIDTH (DATA_WIDTH),
      .RESET_PC   (RESET_PC)
   ) u_program_counter (
      .clock        (clock),
      .reset        (reset),
      .pc_jump      (pc_jump),
      .pc_inc       (pc_inc),
      .pc_jump_data (pc_jump_data),
      .pc_read_data (pc_read_data)
   );

endmodule

// File: tb/tb_register_pc_unit.sv
// Directed self-checking bench for register_pc_unit.
module tb_register_pc_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  write_index;
   logic        write;
   logic [31:0] write_data;
   logic        write_immediate;
   logic [15:0] write_immediate_data;
   logic [1:0]  write_immediate_type;
   logic [3:0]  read_reg1_index;
   logic [3:0]  read_reg2_index;
   logic [3:0]  read_reg3_index;
   logic [31:0] read_reg1_data;
   logic [31:0] read_reg2_data;
   logic [31:0] read_reg3_data;
   logic        pc_jump;
   logic        pc_inc;
   logic [31:0] pc_jump_data;
   logic [31:0] pc_read_data;

   int compare_count = 0;
   int mismatch_count = 0;

   register_pc_unit dut (
      .clock                (clock),
      .reset                (reset),
      .write_index          (write_index),
      .write                (write),
      .write_data           (write_data),
      .write_immediate      (write_immediate),
      .write_immediate_data (write_immediate_data),
      .write_immediate_type (write_immediate_type),
      .read_reg1_index      (read_reg1_index),
      .read_reg2_index      (read_reg2_index),
      .read_reg3_index      (read_reg3_index),
      .read_reg1_data       (read_reg1_data),
      .read_reg2_data       (read_reg2_data),
      .read_reg3_data       (read_reg3_data),
      .pc_jump              (pc_jump),
      .pc_inc               (pc_inc),
      .pc_jump_data         (pc_jump_data),
      .pc_read_data         (pc_read_data)
   );

   always #5 clock = ~clock;

   task automatic check_value(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compare_count++;
      if (observed !== expected) begin
         mismatch_count++;
         $display("FAIL %s: got %08h expected %08h", tag, observed, expected);
      end
   endtask

   // One rising edge, then settle before sampling or changing inputs.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      reset = 1'b0; write = 1'b0; write_immediate = 1'b0;
      pc_jump = 1'b0; pc_inc = 1'b0;
   endtask

   task automatic imm_step(input logic [1:0] it, input logic [15:0] imm,
                           input logic [31:0] expected, input string tag);
      write_index = 4'd2; write_immediate = 1'b1;
      write_immediate_type = it; write_immediate_data = imm;
      tick();
      write_immediate = 1'b0;
      check_value(tag, read_reg3_data, expected);
   endtask

   initial begin
      idle_inputs();
      write_index = 4'd0; write_data = 32'h0; write_immediate_data = 16'h0;
      write_immediate_type = 2'd0; pc_jump_data = 32'h0;
      read_reg1_index = 4'd0; read_reg2_index = 4'd1; read_reg3_index = 4'd2;

      // Reset
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_value("reset_r0", read_reg1_data, 32'h0);
      check_value("reset_r1", read_reg2_data, 32'h0);
      check_value("reset_r2", read_reg3_data, 32'h0);
      check_value("reset_pc", pc_read_data, 32'h0);

      // Full write to r2; before the edge the old value is still visible
      write_index = 4'd2; write = 1'b1; write_data = 32'hdeadbeef;
      #1;
      check_value("same_cycle_old", read_reg3_data, 32'h0);
      tick();
      write = 1'b0;
      check_value("full_write_r2", read_reg3_data, 32'hdeadbeef);
      check_value("full_write_r0", read_reg1_data, 32'h0);
      check_value("full_write_r1", read_reg2_data, 32'h0);

      // Immediate modes
      imm_step(2'd0, 16'hdead, 32'hdeaddead, "imm_bottom");
      imm_step(2'd1, 16'hbeef, 32'hbeefdead, "imm_top");
      imm_step(2'd2, 16'h1234, 32'h00001234, "imm_unsigned");
      imm_step(2'd3, 16'hffff, 32'hffffffff, "imm_signed_neg");
      imm_step(2'd3, 16'h7fff, 32'h00007fff, "imm_signed_pos");

      // Full write beats immediate
      write_index = 4'd2; write = 1'b1; write_data = 32'h11111111;
      write_immediate = 1'b1; write_immediate_type = 2'd1; write_immediate_data = 16'h2222;
      tick();
      idle_inputs();
      check_value("write_priority", read_reg3_data, 32'h11111111);

      // Neither enable: no change
      write_data = 32'h99999999;
      tick();
      check_value("no_enable_hold", read_reg3_data, 32'h11111111);

      // r0 is writable, r15 boundary index, same register on two ports
      write_index = 4'd0; write = 1'b1; write_data = 32'ha5a5a5a5;
      tick();
      write_index = 4'd15; write_data = 32'h0f0f0f0f;
      tick();
      write = 1'b0;
      read_reg2_index = 4'd15; read_reg3_index = 4'd0;
      #1;
      check_value("r0_writable", read_reg1_data, 32'ha5a5a5a5);
      check_value("r15_write", read_reg2_data, 32'h0f0f0f0f);
      check_value("dual_port_r0", read_reg3_data, 32'ha5a5a5a5);
      read_reg2_index = 4'd1; read_reg3_index = 4'd2;

      // PC sequence (PC still 0 since reset)
      check_value("pc_still_reset", pc_read_data, 32'h0);
      pc_inc = 1'b1;
      tick();
      pc_inc = 1'b0;
      check_value("pc_inc", pc_read_data, 32'h4);
      pc_jump = 1'b1; pc_jump_data = 32'hdeadbeef;
      tick();
      pc_jump = 1'b0;
      check_value("pc_jump", pc_read_data, 32'hdeadbeef);
      pc_jump = 1'b1; pc_inc = 1'b1; pc_jump_data = 32'h100;
      tick();
      idle_inputs();
      check_value("pc_jump_over_inc", pc_read_data, 32'h100);
      pc_jump = 1'b1; pc_jump_data = 32'hfffffffc;
      tick();
      pc_jump = 1'b0;
      check_value("pc_jump_top", pc_read_data, 32'hfffffffc);
      pc_inc = 1'b1;
      tick();
      check_value("pc_wrap", pc_read_data, 32'h0);
      tick();
      pc_inc = 1'b0;
      check_value("pc_inc_after_wrap", pc_read_data, 32'h4);
      tick();
      tick();
      check_value("pc_hold", pc_read_data, 32'h4);

      // Register write and PC jump in the same cycle
      write_index = 4'd1; write = 1'b1; write_data = 32'h12345678;
      pc_jump = 1'b1; pc_jump_data = 32'h00000203;
      tick();
      idle_inputs();
      check_value("concurrent_reg", read_reg2_data, 32'h12345678);
      check_value("concurrent_pc_unaligned", pc_read_data, 32'h00000203);

      // Reset overrides inc and write
      reset = 1'b1; pc_inc = 1'b1;
      write = 1'b1; write_index = 4'd2; write_data = 32'h55555555;
      tick();
      idle_inputs();
      check_value("midreset_pc", pc_read_data, 32'h0);
      check_value("midreset_r2", read_reg3_data, 32'h0);
      check_value("midreset_r0", read_reg1_data, 32'h0);
      check_value("midreset_r1", read_reg2_data, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
      $finish;
   end

endmodule
